// File: rtl/komandara_axi4lite_sram.sv
// Komandara AXI4-Lite SRAM slave.
// A DEPTH_WORDS x DATA_WIDTH register array behind an AXI4-Lite slave port.
// The write path (AW/W/B) and the read path (AR/R) are completely independent
// state machines that share only the storage array. Every ready/valid output
// is decoded from registered state, so no valid input ever reaches a ready
// output combinationally. Addresses are rebased against BASE_ADDR; anything
// outside the window answers SLVERR and never touches the array.

module komandara_axi4lite_sram #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  // Write address channel
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
  input  logic [2:0]              s_axi_awprot_i,
  input  logic                    s_axi_awvalid_i,
  output logic                    s_axi_awready_o,

  // Write data channel
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                    s_axi_wvalid_i,
  output logic                    s_axi_wready_o,

  // Write response channel
  output logic [1:0]              s_axi_bresp_o,
  output logic                    s_axi_bvalid_o,
  input  logic                    s_axi_bready_i,

  // Read address channel
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
  input  logic [2:0]              s_axi_arprot_i,
  input  logic                    s_axi_arvalid_i,
  output logic                    s_axi_arready_o,

  // Read data channel
  output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]              s_axi_rresp_o,
  output logic                    s_axi_rvalid_o,
  input  logic                    s_axi_rready_i
);

  // Geometry of the array: bytes per word, byte-offset bits, word-index bits
  // and the size of the decoded window in bytes (one bit wider than the
  // address so the comparison cannot overflow).
  localparam int                  STRB_W     = DATA_WIDTH / 8;
  localparam int                  OFF_W      = $clog2(STRB_W);
  localparam int                  IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * STRB_W);

  // AXI response codes used by this slave.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write state machine encoding.
  localparam logic [1:0] WR_IDLE    = 2'd0;
  localparam logic [1:0] WR_HAVE_AW = 2'd1;
  localparam logic [1:0] WR_HAVE_W  = 2'd2;
  localparam logic [1:0] WR_RESP    = 2'd3;

  // Read state machine encoding.
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RESP = 1'b1;

  // Storage. Deliberately left out of reset: contents are undefined until
  // written and survive a reset pulse.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // Write path state and the half of a write that arrived first.
  logic [1:0]            r_wr_state;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;

  // Read path state and the registered response.
  logic [0:0]            r_rd_state;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // Write path combinational signals.
  logic                  w_awready;
  logic                  w_wready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic [1:0]            w_wr_next;
  logic                  w_wr_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic                  w_wr_in_range;
  logic [IDX_W-1:0]      w_wr_idx;

  // Read path combinational signals.
  logic                  w_arready;
  logic                  w_ar_hs;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic                  w_rd_in_range;
  logic [IDX_W-1:0]      w_rd_idx;

  // The protection attributes carry no meaning for a plain memory.
  logic                  w_unused_prot;
  assign w_unused_prot = ^{s_axi_awprot_i, s_axi_arprot_i};

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------

  // Each channel is ready only while its own half of the pair is still
  // missing; both close while the response is outstanding.
  assign w_awready = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_W);
  assign w_wready  = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_AW);

  assign w_aw_hs = s_axi_awvalid_i && w_awready;
  assign w_w_hs  = s_axi_wvalid_i  && w_wready;

  // Pick each half of the write from the channel if it arrives on this edge,
  // otherwise from the holding register filled by an earlier handshake.
  assign w_wr_addr = (r_wr_state == WR_HAVE_AW) ? r_awaddr : s_axi_awaddr_i;
  assign w_wr_data = (r_wr_state == WR_HAVE_W)  ? r_wdata  : s_axi_wdata_i;
  assign w_wr_strb = (r_wr_state == WR_HAVE_W)  ? r_wstrb  : s_axi_wstrb_i;

  // Rebase against the window; addresses below BASE_ADDR wrap to a huge
  // offset and therefore fall out of range as well.
  assign w_wr_off      = w_wr_addr - BASE_ADDR;
  assign w_wr_in_range = ({1'b0, w_wr_off} < SPAN_BYTES);
  assign w_wr_idx      = w_wr_off[OFF_W+IDX_W-1:OFF_W];

  // Next-state decode: collect AW and W in either order, then wait for bready.
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wr_next = WR_RESP;
        end else if (w_aw_hs) begin
          w_wr_next = WR_HAVE_AW;
        end else if (w_w_hs) begin
          w_wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_w_hs) begin
          w_wr_next = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        if (w_aw_hs) begin
          w_wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi_bready_i) begin
          w_wr_next = WR_IDLE;
        end
      end
      default: begin
        w_wr_next = WR_IDLE;
      end
    endcase
  end

  // The edge that moves the machine into WR_RESP is the edge that completes
  // the AW/W pair; that is when the array is updated.
  assign w_wr_commit = (w_wr_next == WR_RESP) && (r_wr_state != WR_RESP);

  // Write FSM, half-transaction holding registers and the B response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= WR_IDLE;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_aw_hs) begin
        r_awaddr <= s_axi_awaddr_i;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata_i;
        r_wstrb <= s_axi_wstrb_i;
      end
      if (w_wr_commit) begin
        r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Byte-lane masked update of the array on the completing edge only.
  always_ff @(posedge clk_i) begin
    if (w_wr_commit && w_wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_wr_strb[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
  end

  assign s_axi_awready_o = w_awready;
  assign s_axi_wready_o  = w_wready;
  assign s_axi_bvalid_o  = (r_wr_state == WR_RESP);
  assign s_axi_bresp_o   = r_bresp;

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------

  assign w_arready = (r_rd_state == RD_IDLE);
  assign w_ar_hs   = s_axi_arvalid_i && w_arready;

  assign w_rd_off      = s_axi_araddr_i - BASE_ADDR;
  assign w_rd_in_range = ({1'b0, w_rd_off} < SPAN_BYTES);
  assign w_rd_idx      = w_rd_off[OFF_W+IDX_W-1:OFF_W];

  // Read FSM: capture the word on the AR handshake and hold it until rready.
  // The array is sampled before any same-edge write lands, so a colliding
  // read returns the old contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rdata    <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
            r_rresp    <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            r_rd_state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s_axi_rready_i) begin
            r_rd_state <= RD_IDLE;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  assign s_axi_arready_o = w_arready;
  assign s_axi_rvalid_o  = (r_rd_state == RD_RESP);
  assign s_axi_rdata_o   = r_rdata;
  assign s_axi_rresp_o   = r_rresp;

endmodule

// File: doc/komandara_axi4lite_sram.md
KOMANDARA_AXI4LITE_SRAM -- requirements
Module: komandara_axi4lite_sram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32 or 64.
REQ-003 The block SHALL have parameter DEPTH_WORDS, default 1024, memory depth in words; power of two, at least 2.
REQ-004 The block SHALL have parameter BASE_ADDR, default '0, byte address of word 0; aligned to DEPTH_WORDS*DATA_WIDTH/8.
REQ-005 The block SHALL have ports clk_i (input, 1, sole clock) and rst_i (input, 1). rst_i is the reset: asynchronous, active-high.
REQ-006 The block SHALL have the AW channel ports s_axi_awaddr_i (in, ADDR_WIDTH), s_axi_awprot_i (in, 3, ignored), s_axi_awvalid_i (in, 1) and s_axi_awready_o (out, 1).
REQ-007 The block SHALL have the W channel ports s_axi_wdata_i (in, DATA_WIDTH), s_axi_wstrb_i (in, DATA_WIDTH/8), s_axi_wvalid_i (in, 1) and s_axi_wready_o (out, 1).
REQ-008 The block SHALL have the B channel ports s_axi_bresp_o (out, 2), s_axi_bvalid_o (out, 1) and s_axi_bready_i (in, 1).
REQ-009 The block SHALL have the AR channel ports s_axi_araddr_i (in, ADDR_WIDTH), s_axi_arprot_i (in, 3, ignored), s_axi_arvalid_i (in, 1) and s_axi_arready_o (out, 1).
REQ-010 The block SHALL have the R channel ports s_axi_rdata_o (out, DATA_WIDTH), s_axi_rresp_o (out, 2), s_axi_rvalid_o (out, 1) and s_axi_rready_i (in, 1).

Function
REQ-011 The block SHALL act as an AXI4-Lite slave backed by a DEPTH_WORDS x DATA_WIDTH register array, with write and read paths fully independent.
REQ-012 The block SHALL compute offset = addr - BASE_ADDR (modulo 2^ADDR_WIDTH) and the word index as offset[OFF_W+IDX_W-1:OFF_W], where OFF_W = log2(DATA_WIDTH/8) and IDX_W = log2(DEPTH_WORDS).
REQ-013 The block SHALL ignore the low OFF_W address bits, so unaligned addresses hit the containing word.
REQ-014 The block SHALL treat an address as out of range when offset >= DEPTH_WORDS*DATA_WIDTH/8; this covers addresses below BASE_ADDR, because the subtraction wraps.
REQ-015 The write FSM SHALL have four states: WR_IDLE, WR_HAVE_AW, WR_HAVE_W and WR_RESP.
REQ-016 s_axi_awready_o SHALL be 1 in WR_IDLE and WR_HAVE_W, and 0 otherwise.
REQ-017 s_axi_wready_o SHALL be 1 in WR_IDLE and WR_HAVE_AW, and 0 otherwise.
REQ-018 Both ready outputs SHALL be decoded from state only, with no combinational path from any valid input.
REQ-019 In WR_IDLE: an AW handshake alone SHALL latch the address and go to WR_HAVE_AW.
REQ-020 In WR_IDLE: a W handshake alone SHALL latch data and strobe and go to WR_HAVE_W.
REQ-021 In WR_IDLE: AW and W handshakes in the same cycle SHALL go directly to WR_RESP.
REQ-022 The write to memory SHALL occur on the clock edge that completes the AW/W pair, byte lane i updated only where wstrb[i]=1.
REQ-023 An out-of-range write SHALL leave memory unchanged.
REQ-024 On entering WR_RESP, s_axi_bvalid_o SHALL be 1 from the next cycle, with bresp 2'b00 (OKAY) or 2'b10 (SLVERR, out of range).
REQ-025 bvalid and bresp SHALL hold stable until s_axi_bready_i=1, and the FSM SHALL then return to WR_IDLE on that edge.
REQ-026 Write latency SHALL be 1 cycle from the completing handshake to bvalid.
REQ-027 Write throughput SHALL be at most one write per 2 cycles.
REQ-028 The read FSM SHALL have two states: RD_IDLE (s_axi_arready_o=1) and RD_RESP (s_axi_arready_o=0).
REQ-029 An AR handshake in RD_IDLE SHALL register rdata (memory word, or 0 if out of range) and rresp (OKAY or SLVERR), then go to RD_RESP.
REQ-030 s_axi_rvalid_o SHALL be 1 in RD_RESP, with rdata and rresp held stable until s_axi_rready_i=1, then return to RD_IDLE.
REQ-031 Read latency SHALL be 1 cycle from the AR handshake to rvalid.
REQ-032 When a read and a write to the same word complete on the same edge, the read SHALL return the pre-write data.
REQ-033 The block SHALL never drop or duplicate a transaction under any valid/ready interleaving, including valid deasserting while ready=0.

Reset
REQ-034 While rst_i=1 (asynchronous assert): both FSMs SHALL be idle, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, and awready=wready=arready=1.
REQ-035 Memory contents SHALL NOT be reset and are undefined until written.
REQ-036 Reset asserted mid-transaction SHALL abort that transaction; a memory write SHALL have occurred only if its completing edge preceded the reset.
REQ-037 Deassertion of rst_i SHALL be synchronous to clk_i, handled externally.

Verification
REQ-038 AW 0x0000_0010 and W 0xDEADBEEF/strb 0xF in the same cycle, bready=1 -> bvalid next cycle with OKAY; then AR 0x10 -> rdata 0xDEADBEEF, OKAY, 1 cycle after the AR handshake.
REQ-039 W 0x11223344 presented 3 cycles before AW 0x14, then wstrb 0x5 over existing 0xFFFFFFFF -> bvalid 1 cycle after the AW handshake; readback 0xFF22FF44.
REQ-040 With DEPTH_WORDS=1024 and BASE_ADDR=0, a write and a read at 0x1000 -> bresp=rresp=2'b10, rdata=0, and word 0 unchanged.
REQ-041 bready held 0 for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; a new AW is accepted the cycle after bready=1.
REQ-042 A write to 0x20 (old 0xA, new 0xB) and an AR to 0x20 handshaking on the same edge -> rdata 0xA; a following read returns 0xB.
REQ-043 rst_i pulsed while in WR_RESP and RD_RESP -> bvalid=rvalid=0 immediately (asynchronous), and all ready outputs are 1 after release.
